// File: rtl/alu_flag_stage.sv
// alu_flag_stage: EX->MEM pipeline register for the ALU result and NZCV flags, with B.cond resolution
//   clk, reset (async, active-low)
//   ex_valid, stall, flush, set_flags, alu_result[WIDTH], negative, zero, overflow, carry_out : EX inputs
//   cond_valid, cond[4] : B.cond to resolve this cycle
//   mem_valid, mem_result[WIDTH], flags[4] {N,Z,C,V} : registered outputs; branch_taken : combinational
//   ALU_FLAG_FWD_EN : when defined, a same-cycle EX flag setter is bypassed into the branch decision
module alu_flag_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             negative,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carry_out,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [3:0]       flags,
  output logic             branch_taken
);
  logic [3:0] ex_flags;
  logic [3:0] eff;
  logic [7:0] base_v;
  logic       n, z, c, v, base;
  assign ex_flags = {negative, zero, carry_out, overflow};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      flags      <= 4'b0000;
    end else if (flush) begin
      mem_valid <= 1'b0;
    end else if (!stall) begin
      mem_valid <= ex_valid;
      if (ex_valid) mem_result <= alu_result;
      if (ex_valid && set_flags) flags <= ex_flags;
    end
`ifdef ALU_FLAG_FWD_EN
  assign eff = (ex_valid && set_flags && !flush) ? ex_flags : flags;
`else
  assign eff = flags;
`endif
  assign {n, z, c, v} = eff;
  // Odd condition codes are the complement of the even code below them, except 1111 (always true)
  assign base_v = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign base = base_v[cond[3:1]];
  assign branch_taken = cond_valid && (base ^ (cond[0] && cond[3:1] != 3'b111));
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed self-checking bench for alu_flag_stage
module tb_alu_flag_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, stall, flush, set_flags;
  logic [63:0] alu_result;
  logic        negative, zero, overflow, carry_out;
  logic        cond_valid;
  logic [3:0]  cond;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic [3:0]  flags;
  logic        branch_taken;
  int          errors = 0;
  int          checks = 0;

  alu_flag_stage #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .set_flags(set_flags), .alu_result(alu_result), .negative(negative), .zero(zero),
    .overflow(overflow), .carry_out(carry_out), .cond_valid(cond_valid), .cond(cond),
    .mem_valid(mem_valid), .mem_result(mem_result), .flags(flags), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic vld, input logic sf, input logic [3:0] nzcv, input logic [63:0] res);
    ex_valid = vld;
    set_flags = sf;
    {negative, zero, carry_out, overflow} = nzcv;
    alu_result = res;
  endtask

  task automatic br(input logic [3:0] c, input logic exp, input string tag);
    cond_valid = 1'b1;
    cond = c;
    #1;
    check(tag, branch_taken, exp);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; cond_valid = 1'b0; cond = 4'h0;
    ex(1'b0, 1'b0, 4'b0000, 64'h0);
    #3;
    check("rst_valid", mem_valid, 0);
    check("rst_result", mem_result, 0);
    check("rst_flags", flags, 0);
    br(4'b0000, 1'b0, "rst_eq");
    br(4'b0001, 1'b1, "rst_ne");
    br(4'b1110, 1'b1, "rst_al");
    step();
    check("rst_hold_valid", mem_valid, 0);
    reset = 1'b1;
    cond_valid = 1'b0;
    cond = 4'b1110;
    ex(1'b1, 1'b1, 4'b0110, 64'h0);
    #1;
    check("bt_no_condvalid", branch_taken, 0);
    step();
    check("cap_valid", mem_valid, 1);
    check("cap_result", mem_result, 0);
    check("cap_flags", flags, 4'b0110);
    ex(1'b1, 1'b0, 4'b1000, 64'h11);
    br(4'b0000, 1'b1, "cap_eq");
    cond_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      alu_result = 64'h11 * i;
      step();
      check("nosf_flags", flags, 4'b0110);
      check("nosf_result", mem_result, 64'h11 * i);
    end
    ex(1'b0, 1'b0, 4'b0000, 64'hdead);
    step();
    check("idle_valid", mem_valid, 0);
    check("idle_result", mem_result, 64'h33);
    ex(1'b1, 1'b1, 4'b0000, 64'h44);
    step();
    check("zero_flags", flags, 4'b0000);
    stall = 1'b1;
    ex(1'b1, 1'b1, 4'b1001, 64'h55);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_flags", flags, 4'b0000);
      check("stall_valid", mem_valid, 1);
      check("stall_result", mem_result, 64'h44);
    end
    stall = 1'b0;
    step();
    check("unstall_flags", flags, 4'b1001);
    check("unstall_result", mem_result, 64'h55);
    ex(1'b0, 1'b0, 4'b0000, 64'h0);
    br(4'b1010, 1'b1, "dec_ge");
    br(4'b1011, 1'b0, "dec_lt");
    br(4'b0100, 1'b1, "dec_mi");
    br(4'b0101, 1'b0, "dec_pl");
    br(4'b0110, 1'b1, "dec_vs");
    br(4'b0010, 1'b0, "dec_hs");
    br(4'b0011, 1'b1, "dec_lo");
    br(4'b1000, 1'b0, "dec_hi");
    br(4'b1001, 1'b1, "dec_ls");
    br(4'b1100, 1'b1, "dec_gt");
    br(4'b1101, 1'b0, "dec_le");
    br(4'b1111, 1'b1, "dec_nv");
    flush = 1'b1; stall = 1'b1;
    ex(1'b1, 1'b1, 4'b1000, 64'h66);
    br(4'b1011, 1'b0, "flush_lt_pre");
    step();
    check("flush_valid", mem_valid, 0);
    check("flush_flags", flags, 4'b1001);
    check("flush_result", mem_result, 64'h55);
    stall = 1'b0;
    ex(1'b1, 1'b1, 4'b0000, 64'h77);
    step();
    check("flush2_valid", mem_valid, 0);
    check("flush2_flags", flags, 4'b1001);
    check("flush2_result", mem_result, 64'h55);
    flush = 1'b0;
    ex(1'b0, 1'b0, 4'b0000, 64'h0);
    br(4'b1011, 1'b0, "flush_lt_post");
    cond_valid = 1'b0;
    ex(1'b1, 1'b1, 4'b0000, 64'h0);
    step();
    check("clr_flags", flags, 4'b0000);
    ex(1'b1, 1'b1, 4'b1000, 64'h1);
`ifdef ALU_FLAG_FWD_EN
    br(4'b1011, 1'b1, "fwd_lt");
`else
    br(4'b1011, 1'b0, "fwd_lt");
`endif
    step();
    ex(1'b0, 1'b0, 4'b0000, 64'h0);
    br(4'b1011, 1'b1, "lt_after");
    cond_valid = 1'b0;
    ex(1'b1, 1'b1, 4'b1111, 64'habcd);
    step();
    check("all_flags", flags, 4'b1111);
    check("all_valid", mem_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", mem_valid, 0);
    check("async_result", mem_result, 0);
    check("async_flags", flags, 0);
    ex(1'b0, 1'b0, 4'b0000, 64'h0);
    br(4'b1110, 1'b1, "async_al");
    br(4'b0000, 1'b0, "async_eq");
    cond_valid = 1'b0;
    ex(1'b1, 1'b1, 4'b1111, 64'h12);
    step();
    check("held_flags", flags, 0);
    check("held_valid", mem_valid, 0);
    reset = 1'b1;
    ex(1'b1, 1'b1, 4'b0010, 64'h99);
    step();
    check("post_flags", flags, 4'b0010);
    check("post_result", mem_result, 64'h99);
    check("post_valid", mem_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 Parameter: WIDTH, 64, datapath width of the captured ALU result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-004 ex_valid  input  1  EX-stage instruction valid.
REQ-005 stall  input  1  hold all stage state this cycle.
REQ-006 flush  input  1  kill EX-stage instruction this cycle.
REQ-007 set_flags  input  1  EX instruction is flag-setting (ADDS/SUBS/ANDS/CMP).
REQ-008 alu_result  input  WIDTH  ALU result from EX.
REQ-009 negative, zero, overflow, carry_out  input  1 each  ALU flags from EX.
REQ-010 cond_valid  input  1  B.cond being resolved this cycle.
REQ-011 cond  input  4  ARM condition code of the B.cond.
REQ-012 mem_valid  output  1  MEM-stage valid.
REQ-013 mem_result  output  WIDTH  registered ALU result.
REQ-014 flags  output  4  architectural NZCV register, packed {N,Z,C,V}.
REQ-015 branch_taken  output  1  combinational B.cond decision.

Function
REQ-016 Update on rising edge, priority flush > stall > normal.
REQ-017 Normal (no stall, no flush): mem_valid <= ex_valid; mem_result <= alu_result when ex_valid, else hold.
REQ-018 Normal with ex_valid & set_flags: flags <= {negative, zero, carry_out, overflow}; otherwise flags hold.
REQ-019 Stall without flush: mem_valid, mem_result, flags all hold.
REQ-020 Flush (with or without stall): mem_valid <= 0, mem_result holds, flags SHALL NOT update from the killed instruction.
REQ-021 Latency: result/flags visible on outputs exactly one cycle after capture edge.
REQ-022 Effective flags eff = forwarded value per REQ-030, else flags register.
REQ-023 branch_taken = cond_valid & cond_true(cond, eff); zero when cond_valid = 0.
REQ-024 cond_true: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-025 cond_true: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 always true.
REQ-026 Non-flag-setting instructions leave flags untouched however many pass.
REQ-027 Back-to-back flag setters: each edge captures the newest; no queueing.

Reset
REQ-028 While reset = 0: mem_valid = 0, mem_result = 0, flags = 4'b0000, independent of clk.
REQ-029 Reset mid-operation discards any in-flight instruction; first capture occurs on the first rising edge with reset = 1; branch_taken after reset uses flags = 0000 (EQ false, NE true, AL true).

Configuration
REQ-030 Macro ALU_FLAG_FWD_EN defined: when ex_valid & set_flags & !flush, eff = {negative, zero, carry_out, overflow} from the current EX inputs (same-cycle bypass, stall irrelevant); otherwise eff = flags.
REQ-031 Macro ALU_FLAG_FWD_EN undefined: eff = flags always; a B.cond needs one cycle after its flag setter is captured; no bypass logic present.

Verification
REQ-032 Reset low then release; ex_valid=1, set_flags=1, N=0,Z=1,C=1,V=0, result=0 -> next edge mem_valid=1, mem_result=0, flags=0110; cond=0000 with cond_valid=1 -> branch_taken=1.
REQ-033 Capture flags=0110, then ex_valid=1, set_flags=0, N=1,Z=0 for 3 cycles -> flags stays 0110 throughout; mem_result tracks each alu_result.
REQ-034 stall=1 for 2 cycles with ex_valid=1, set_flags=1, flags in 1001 vs stored 0000 -> flags stays 0000, mem_valid/mem_result hold; stall=0 -> flags=1001 next edge.
REQ-035 flush=1 and stall=1 together, ex_valid=1, set_flags=1, flags in 1000 -> next edge mem_valid=0, flags unchanged; cond=1011 (LT) evaluates against unchanged flags.
REQ-036 Stored flags 0000, EX flag setter N=1,V=0 with cond_valid=1, cond=1011 same cycle -> branch_taken=1 with ALU_FLAG_FWD_EN, 0 without.
REQ-037 Assert reset mid-stream with flags=1111 and mem_valid=1 -> outputs clear asynchronously before next clk edge; cond=1110 still gives branch_taken=1.
